mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Multi-cycle control sequencer for the 32-bit processor datapath (PC, instruction memory, decoder, register file, Execute, DataMemory). It replaces the single-cycle combinational controller. Each instruction is stepped through FETCH/DECODE/EXEC/MEM/WB states, and the block emits per-state enables for the PC, instruction register, register file, and data memory. It also tolerates multi-cycle memory/IO accesses via a ready handshake and counts retired instructions.

## Interface
Parameters:
- OP_BIT_WIDTH, 4, width of op1/op2 fields
- DBITS, 32, width of retired-instruction counter

Ports:
- clk  in  1  processor clock (PLL c0); all state changes on rising edge
- reset  in  1  synchronous, active-high (driven from ~lock)
- op1  in  OP_BIT_WIDTH  primary opcode from latched instruction register
- cond_true  in  1  Execute condition output (outCond), valid in EXEC
- mem_ready  in  1  DataMemory/IO access complete this cycle
- ir_load  out  1  latch instruction word into IR
- pc_load  out  1  update PC this cycle
- pc_sel  out  2  PC source: 0 = PC+4, 1 = branch target (PC+4+imm32*4), 2 = ALU result (JAL)
- alu_src_imm  out  1  Execute B operand = imm32 (else reg rs2)
- reg_wr_en  out  1  register file write enable
- reg_wr_sel  out  2  write-back source: 0 = ALU, 1 = memory, 2 = PC+4
- mem_rd_en  out  1  data memory / IO read request
- mem_wr_en  out  1  data memory / IO write request
- halted  out  1  illegal opcode trapped
- state  out  3  current state encoding (debug, LEDG)
- retired  out  DBITS  retired instruction count

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- FETCH: ir_load=1 -> DECODE.
- DECODE: register file read settles; no enables -> EXEC, unless op1 is not one of {ALUR 0000, ALUI 1000, CMPR 0010, CMPI 1010, BCOND 0110, SW 0101, LW 1001, JAL 1011}, in which case -> HALT.
- EXEC: alu_src_imm=1 for ALUI, CMPI, LW, SW, JAL; 0 otherwise.
  - ALUR/ALUI/CMPR/CMPI/JAL -> WB.
  - LW/SW -> MEM.
  - BCOND: pc_load=1, pc_sel = cond_true ? 1 : 0, retire -> FETCH.
- MEM: alu_src_imm=1 held.
  - LW: mem_rd_en=1.
  - SW: mem_wr_en=1.
  - Held every cycle while mem_ready=0.
  - mem_ready=1 with LW -> WB.
  - mem_ready=1 with SW: pc_load=1, pc_sel=0, retire -> FETCH.
- WB: reg_wr_en=1; pc_load=1; retire -> FETCH.
  - reg_wr_sel = 1 for LW, 2 for JAL, 0 otherwise.
  - pc_sel = 2 for JAL, 0 otherwise.
  - alu_src_imm held as in EXEC.
- HALT: all enables 0, halted=1; remains until reset.
- Outputs are decoded combinationally from the state register and op1. Any enable not listed for a state is 0.
- retired increments by 1 on each retire cycle and wraps 0xFFFFFFFF -> 0.

## Timing
- Reset (sampled high at an edge): next state FETCH, retired=0, halted=0.
  - While reset is high, all enables are forced to 0 regardless of state.
  - Reset mid-instruction or mid-MEM-wait abandons the access; no write occurs in the reset cycle.
- Cycles per instruction, with zero memory wait:
  - ALU/CMP/JAL: 4.
  - BCOND: 3.
  - SW: 4.
  - LW: 5.
  - Each cycle of mem_ready=0 in MEM adds 1.
- mem_wr_en is a level request held until the accepting cycle. DataMemory must commit exactly once, on the edge where mem_wr_en=1 and mem_ready=1.
- mem_ready is ignored outside MEM.
- op1 must be stable from DECODE through the retire cycle (the IR is only loaded in FETCH).
- pc_load is asserted exactly once per retired instruction and never in FETCH/DECODE/HALT.

## Test plan
- Reset then ALUI (op1=1000), mem_ready=1:
  - ir_load at cycle 0, alu_src_imm=1 at cycle 2.
  - reg_wr_en=1, reg_wr_sel=0, pc_load=1, pc_sel=0 at cycle 3.
  - retired=1 after the edge.
- BCOND with cond_true=1: pc_load=1, pc_sel=1 in EXEC (cycle 2), no reg_wr_en. Repeat with cond_true=0: pc_sel=0. Each retires in 3 cycles.
- LW with mem_ready low for 3 MEM cycles:
  - mem_rd_en high for 4 cycles.
  - WB then has reg_wr_sel=1.
  - Total 8 cycles; retired increments once.
- SW with mem_ready=0 for 2 cycles:
  - mem_wr_en high for 3 consecutive cycles.
  - pc_load only on the third; reg_wr_en never asserted.
- JAL: WB has reg_wr_en=1, reg_wr_sel=2, pc_sel=2. Then illegal op1=1111: DECODE -> HALT, halted=1, and no further ir_load/pc_load for 20 cycles.
- Reset mid-operation:
  - Assert reset during an SW MEM wait: mem_wr_en=0 in the reset cycle, state=FETCH after the edge.
  - Preload retired=0xFFFFFFFF (via 2^32 retires, or force in sim), retire one instruction: retired=0.

Source files
------------

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// emits per-state datapath enables and counts retired instructions.
module mc_sequencer #(
  parameter int OP_BIT_WIDTH = 4,
  parameter int DBITS        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OP_BIT_WIDTH-1:0] op1,
  input  logic                    cond_true,
  input  logic                    mem_ready,
  output logic                    ir_load,
  output logic                    pc_load,
  output logic [1:0]              pc_sel,
  output logic                    alu_src_imm,
  output logic                    reg_wr_en,
  output logic [1:0]              reg_wr_sel,
  output logic                    mem_rd_en,
  output logic                    mem_wr_en,
  output logic                    halted,
  output logic [2:0]              state,
  output logic [DBITS-1:0]        retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [OP_BIT_WIDTH-1:0] OP_ALUR  = OP_BIT_WIDTH'(4'b0000);
  localparam logic [OP_BIT_WIDTH-1:0] OP_ALUI  = OP_BIT_WIDTH'(4'b1000);
  localparam logic [OP_BIT_WIDTH-1:0] OP_CMPR  = OP_BIT_WIDTH'(4'b0010);
  localparam logic [OP_BIT_WIDTH-1:0] OP_CMPI  = OP_BIT_WIDTH'(4'b1010);
  localparam logic [OP_BIT_WIDTH-1:0] OP_BCOND = OP_BIT_WIDTH'(4'b0110);
  localparam logic [OP_BIT_WIDTH-1:0] OP_SW    = OP_BIT_WIDTH'(4'b0101);
  localparam logic [OP_BIT_WIDTH-1:0] OP_LW    = OP_BIT_WIDTH'(4'b1001);
  localparam logic [OP_BIT_WIDTH-1:0] OP_JAL   = OP_BIT_WIDTH'(4'b1011);

  state_t state_q, state_d;
  logic   retire;
  logic   is_lw, is_sw, is_jal, is_bcond, is_legal, uses_imm;

  assign is_lw    = (op1 == OP_LW);
  assign is_sw    = (op1 == OP_SW);
  assign is_jal   = (op1 == OP_JAL);
  assign is_bcond = (op1 == OP_BCOND);
  assign is_legal = (op1 == OP_ALUR) || (op1 == OP_ALUI) || (op1 == OP_CMPR) ||
                    (op1 == OP_CMPI) || is_bcond || is_sw || is_lw || is_jal;
  assign uses_imm = (op1 == OP_ALUI) || (op1 == OP_CMPI) || is_lw || is_sw || is_jal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + DBITS'(1);
    end
  end

  // Memory handshake: mem_rd_en/mem_wr_en are level requests held in MEM until the
  // cycle mem_ready=1; that cycle is the single accepting edge. mem_ready is ignored elsewhere.
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    pc_sel      = 2'd0;
    alu_src_imm = 1'b0;
    reg_wr_en   = 1'b0;
    reg_wr_sel  = 2'd0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_load = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = is_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        alu_src_imm = uses_imm;
        if (is_bcond) begin
          pc_load = 1'b1;
          pc_sel  = cond_true ? 2'd1 : 2'd0;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_src_imm = 1'b1;
        mem_rd_en   = is_lw;
        mem_wr_en   = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            pc_load = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        alu_src_imm = uses_imm;
        reg_wr_en   = 1'b1;
        reg_wr_sel  = is_lw ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
        pc_load     = 1'b1;
        pc_sel      = is_jal ? 2'd2 : 2'd0;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Reset abandons any in-flight access: nothing may be written or loaded in that cycle.
    if (reset) begin
      retire      = 1'b0;
      ir_load     = 1'b0;
      pc_load     = 1'b0;
      pc_sel      = 2'd0;
      alu_src_imm = 1'b0;
      reg_wr_en   = 1'b0;
      reg_wr_sel  = 2'd0;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
    end
  end

  assign halted = (state_q == S_HALT);
  assign state  = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: builds an expected per-cycle output trace from the instruction
// rules, drives it cycle by cycle and compares every output with immediate assertions.
module tb_mc_sequencer;

  localparam int EW = 14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  op1 = 4'd0;
  logic        cond_true = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_load, pc_load, alu_src_imm, reg_wr_en, mem_rd_en, mem_wr_en, halted;
  logic [1:0]  pc_sel, reg_wr_sel;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        w_ir_load, w_pc_load, w_alu_src_imm, w_reg_wr_en, w_mem_rd_en, w_mem_wr_en, w_halted;
  logic [1:0]  w_pc_sel, w_reg_wr_sel;
  logic [2:0]  w_state;
  logic [2:0]  w_retired;

  always #5 clk = ~clk;

  mc_sequencer #(.OP_BIT_WIDTH(4), .DBITS(32)) dut (
    .clk(clk), .reset(reset), .op1(op1), .cond_true(cond_true), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel), .alu_src_imm(alu_src_imm),
    .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .halted(halted), .state(state), .retired(retired)
  );

  // Narrow counter instance so the wrap from all-ones to zero is reachable.
  mc_sequencer #(.OP_BIT_WIDTH(4), .DBITS(3)) dut_w (
    .clk(clk), .reset(reset), .op1(op1), .cond_true(cond_true), .mem_ready(mem_ready),
    .ir_load(w_ir_load), .pc_load(w_pc_load), .pc_sel(w_pc_sel), .alu_src_imm(w_alu_src_imm),
    .reg_wr_en(w_reg_wr_en), .reg_wr_sel(w_reg_wr_sel), .mem_rd_en(w_mem_rd_en),
    .mem_wr_en(w_mem_wr_en), .halted(w_halted), .state(w_state), .retired(w_retired)
  );

  logic [EW-1:0] exp_q[$];
  logic [9:0]    stim_q[$];   // {reset, skip_check, op1[3:0], cond, ready, retire, 1'b0}
  int            errors = 0;
  int            checks = 0;
  logic [31:0]   exp_count = 32'd0;
  logic [3:0]    legal_ops[8] = '{4'h0, 4'h8, 4'h2, 4'hA, 4'h6, 4'h5, 4'h9, 4'hB};

  function automatic logic [EW-1:0] pack(input bit ir, input bit pcl, input logic [1:0] pcs,
                                         input bit imm, input bit rwe, input logic [1:0] rws,
                                         input bit rd, input bit wr, input bit hlt,
                                         input logic [2:0] st);
    return {ir, pcl, pcs, imm, rwe, rws, rd, wr, hlt, st};
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_cycle(input bit rst, input bit skip, input logic [3:0] op, input bit cnd,
                            input bit rdy, input bit ret, input logic [EW-1:0] e);
    stim_q.push_back({rst, skip, op, cnd, rdy, ret, 1'b0});
    exp_q.push_back(e);
  endtask

  // Expected trace of one instruction; wait_cycles = MEM cycles spent with mem_ready low.
  task automatic gen_instr(input logic [3:0] op, input int wait_cycles, input bit cnd);
    bit imm, legal, mem_op, sw_acc, rdy;
    imm    = (op == 4'h8) || (op == 4'hA) || (op == 4'h9) || (op == 4'h5) || (op == 4'hB);
    legal  = imm || (op == 4'h0) || (op == 4'h2) || (op == 4'h6);
    mem_op = (op == 4'h9) || (op == 4'h5);
    push_cycle(0, 0, 4'($urandom_range(0, 15)), rbit(), rbit(), 0, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
    push_cycle(0, 0, op, rbit(), rbit(), 0, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
    if (!legal) return;
    if (op == 4'h6) begin
      push_cycle(0, 0, op, cnd, rbit(), 1, pack(0, 1, cnd ? 2'd1 : 2'd0, 0, 0, 0, 0, 0, 0, 3'd2));
      return;
    end
    push_cycle(0, 0, op, rbit(), rbit(), 0, pack(0, 0, 0, imm, 0, 0, 0, 0, 0, 3'd2));
    if (mem_op) begin
      for (int k = 0; k <= wait_cycles; k++) begin
        rdy    = (k == wait_cycles);
        sw_acc = (op == 4'h5) && rdy;
        push_cycle(0, 0, op, rbit(), rdy, sw_acc,
                   pack(0, sw_acc, 0, 1, 0, 0, op == 4'h9, op == 4'h5, 0, 3'd3));
      end
      if (op == 4'h5) return;
    end
    push_cycle(0, 0, op, rbit(), rbit(), 1,
               pack(0, 1, (op == 4'hB) ? 2'd2 : 2'd0, imm, 1,
                    (op == 4'h9) ? 2'd1 : ((op == 4'hB) ? 2'd2 : 2'd0), 0, 0, 0, 3'd4));
  endtask

  task automatic gen_random(input int n);
    for (int i = 0; i < n; i++)
      gen_instr(legal_ops[$urandom_range(0, 7)], $urandom_range(0, 3), rbit());
  endtask

  task automatic run_queue();
    logic [9:0]    s;
    logic [EW-1:0] e, obs;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset     = s[9];
      op1       = s[7:4];
      cond_true = s[3];
      mem_ready = s[2];
      #1;
      if (!s[8]) begin
        obs = pack(ir_load, pc_load, pc_sel, alu_src_imm, reg_wr_en, reg_wr_sel,
                   mem_rd_en, mem_wr_en, halted, state);
        checks++;
        assert (obs === e) else begin
          errors++;
          $error("FAIL outputs t=%0t observed=%04h expected=%04h", $time, obs, e);
        end
        checks++;
        assert (retired === exp_count) else begin
          errors++;
          $error("FAIL retired t=%0t observed=%0d expected=%0d", $time, retired, exp_count);
        end
        checks++;
        assert (w_retired === exp_count[2:0]) else begin
          errors++;
          $error("FAIL retired_wrap t=%0t observed=%0d expected=%0d", $time, w_retired, exp_count[2:0]);
        end
      end
      @(posedge clk);
      if (s[9]) exp_count = 32'd0;
      else if (s[1]) exp_count = exp_count + 32'd1;
    end
  endtask

  initial begin
    push_cycle(1, 1, 4'h0, 0, 0, 0, '0);
    push_cycle(1, 1, 4'h0, 0, 0, 0, '0);
    gen_instr(4'h8, 0, 0);
    gen_instr(4'h6, 0, 1);
    gen_instr(4'h6, 0, 0);
    gen_instr(4'h9, 3, 0);
    gen_instr(4'h5, 2, 0);
    gen_instr(4'hB, 0, 0);
    gen_random(40);
    // Reset during the third cycle of an SW memory wait.
    push_cycle(0, 0, 4'h3, 0, 1, 0, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
    push_cycle(0, 0, 4'h5, 0, 1, 0, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
    push_cycle(0, 0, 4'h5, 0, 1, 0, pack(0, 0, 0, 1, 0, 0, 0, 0, 0, 3'd2));
    push_cycle(0, 0, 4'h5, 0, 0, 0, pack(0, 0, 0, 1, 0, 0, 0, 1, 0, 3'd3));
    push_cycle(0, 0, 4'h5, 0, 0, 0, pack(0, 0, 0, 1, 0, 0, 0, 1, 0, 3'd3));
    push_cycle(1, 0, 4'h5, 0, 1, 0, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd3));
    gen_instr(4'h0, 0, 0);
    gen_random(10);
    gen_instr(4'hB, 0, 0);
    gen_instr(4'hF, 0, 0);
    for (int i = 0; i < 20; i++)
      push_cycle(0, 0, 4'hF, rbit(), rbit(), 0, pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd7));
    push_cycle(1, 1, 4'hF, 0, 0, 0, '0);
    gen_instr(4'h8, 0, 0);
    gen_random(12);
    run_queue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
